pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core; replaces the hand-written per-stage registers (D/E, E/M, M/W) with one configurable block.
- Carries PC, a packed control word, NCH data channels, destination register, Tnew, exception code and branch-delay flag.
- Adds the following, none of which the fixed-width stage registers provide:
  - a valid bit;
  - flush / bubble insertion that preserves PC and BD for CP0 EPC;
  - a configurable Tnew decrement;
  - a forwarding-ready indication.

---
 rtl/pipe_stage_reg.sv | 91 +++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with bubble insertion and forwarding-ready flag
module pipe_stage_reg #(
  parameter int          DATA_W   = 32,
  parameter int          NCH      = 2,
  parameter int          CTRL_W   = 8,
  parameter int          TNEW_W   = 2,
  parameter int          TNEW_DEC = 1,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic [31:0]           pc_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [NCH*DATA_W-1:0] data_i,
  input  logic [4:0]            a3_i,
  input  logic [TNEW_W-1:0]     tnew_i,
  input  logic [4:0]            exc_i,
  input  logic                  bd_i,
  output logic                  valid_o,
  output logic [31:0]           pc_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [NCH*DATA_W-1:0] data_o,
  output logic [4:0]            a3_o,
  output logic [TNEW_W-1:0]     tnew_o,
  output logic [4:0]            exc_o,
  output logic                  bd_o,
  output logic                  fwd_ok_o
);

  logic                  r_valid;
  logic [31:0]           r_pc;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [NCH*DATA_W-1:0] r_data;
  logic [4:0]            r_a3;
  logic [TNEW_W-1:0]     r_tnew;
  logic [4:0]            r_exc;
  logic                  r_bd;

  logic [31:0]           w_tnew_ext;
  logic [TNEW_W-1:0]     w_tnew_dec;

  // Saturating decrement done at 32 bits so a large TNEW_DEC can never wrap the field.
  assign w_tnew_ext = 32'(tnew_i);
  assign w_tnew_dec = (w_tnew_ext > 32'(TNEW_DEC)) ? TNEW_W'(w_tnew_ext - 32'(TNEW_DEC)) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= PC_RESET;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_a3    <= '0;
      r_tnew  <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
    end else if (flush) begin
      // Bubble keeps PC and BD so CP0 still sees the right EPC.
      r_valid <= 1'b0;
      r_pc    <= pc_i;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_a3    <= '0;
      r_tnew  <= '0;
      r_exc   <= '0;
      r_bd    <= bd_i;
    end else if (en) begin
      r_valid <= valid_i;
      r_pc    <= pc_i;
      r_data  <= data_i;
      r_bd    <= bd_i;
      r_ctrl  <= valid_i ? ctrl_i     : '0;
      r_a3    <= valid_i ? a3_i       : '0;
      r_tnew  <= valid_i ? w_tnew_dec : '0;
      r_exc   <= valid_i ? exc_i      : '0;
    end
  end

  assign valid_o  = r_valid;
  assign pc_o     = r_pc;
  assign ctrl_o   = r_ctrl;
  assign data_o   = r_data;
  assign a3_o     = r_a3;
  assign tnew_o   = r_tnew;
  assign exc_o    = r_exc;
  assign bd_o     = r_bd;
  assign fwd_ok_o = r_valid & (r_a3 != 5'd0) & (r_tnew == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector table plus randomized model comparison for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, en, flush, valid_i, bd_i;
  logic [31:0] pc_i;
  logic [7:0]  ctrl_i;
  logic [63:0] data_i;
  logic [4:0]  a3_i, exc_i;
  logic [1:0]  tnew_i;

  logic        d0_valid, d0_bd, d0_fwd, d1_valid, d1_bd, d1_fwd;
  logic [31:0] d0_pc, d1_pc;
  logic [7:0]  d0_ctrl, d1_ctrl;
  logic [63:0] d0_data, d1_data;
  logic [4:0]  d0_a3, d0_exc, d1_a3, d1_exc;
  logic [1:0]  d0_tnew, d1_tnew;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .NCH(2), .CTRL_W(8), .TNEW_W(2), .TNEW_DEC(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .a3_i(a3_i), .tnew_i(tnew_i), .exc_i(exc_i), .bd_i(bd_i),
    .valid_o(d0_valid), .pc_o(d0_pc), .ctrl_o(d0_ctrl), .data_o(d0_data), .a3_o(d0_a3),
    .tnew_o(d0_tnew), .exc_o(d0_exc), .bd_o(d0_bd), .fwd_ok_o(d0_fwd));

  pipe_stage_reg #(.DATA_W(32), .NCH(2), .CTRL_W(8), .TNEW_W(2), .TNEW_DEC(0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
    .ctrl_i(ctrl_i), .data_i(data_i), .a3_i(a3_i), .tnew_i(tnew_i), .exc_i(exc_i), .bd_i(bd_i),
    .valid_o(d1_valid), .pc_o(d1_pc), .ctrl_o(d1_ctrl), .data_o(d1_data), .a3_o(d1_a3),
    .tnew_o(d1_tnew), .exc_o(d1_exc), .bd_o(d1_bd), .fwd_ok_o(d1_fwd));

  typedef struct {
    logic rst, en, fl, vi; logic [31:0] pc; logic [7:0] ctrl; logic [63:0] data;
    logic [4:0] a3; logic [1:0] tn; logic [4:0] exc; logic bd;
    logic ev; logic [31:0] epc; logic [7:0] ectrl; logic [63:0] edata; logic [4:0] ea3;
    logic [1:0] etn; logic [4:0] eexc; logic ebd, efwd; logic [1:0] etn1; logic efwd1;
  } vec_t;

  typedef struct {
    logic v; logic [31:0] pc; logic [7:0] ctrl; logic [63:0] data;
    logic [4:0] a3; int tnew; logic [4:0] exc; logic bd;
  } st_t;

  vec_t vecs[12];
  st_t  m0, m1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(
    input logic rst, en_v, fl, vi, input logic [31:0] pc, input logic [7:0] ctrl,
    input logic [63:0] data, input logic [4:0] a3, input logic [1:0] tn, input logic [4:0] exc,
    input logic bd, ev, input logic [31:0] epc, input logic [7:0] ectrl, input logic [63:0] edata,
    input logic [4:0] ea3, input logic [1:0] etn, input logic [4:0] eexc, input logic ebd, efwd,
    input logic [1:0] etn1, input logic efwd1);
    vec_t r;
    r.rst = rst; r.en = en_v; r.fl = fl; r.vi = vi; r.pc = pc; r.ctrl = ctrl; r.data = data;
    r.a3 = a3; r.tn = tn; r.exc = exc; r.bd = bd; r.ev = ev; r.epc = epc; r.ectrl = ectrl;
    r.edata = edata; r.ea3 = ea3; r.etn = etn; r.eexc = eexc; r.ebd = ebd; r.efwd = efwd;
    r.etn1 = etn1; r.efwd1 = efwd1;
    return r;
  endfunction

  // Reference: the stage's rules applied in priority order, Tnew as plain integer arithmetic.
  function automatic st_t model_next(input st_t s, input int dec);
    st_t n = s;
    if (!reset) begin
      n = '{1'b0, 32'h3000, 8'h0, 64'h0, 5'h0, 0, 5'h0, 1'b0};
    end else if (flush) begin
      n = '{1'b0, pc_i, 8'h0, 64'h0, 5'h0, 0, 5'h0, bd_i};
    end else if (en) begin
      n.v = valid_i; n.pc = pc_i; n.data = data_i; n.bd = bd_i;
      if (valid_i) begin
        n.ctrl = ctrl_i; n.a3 = a3_i; n.exc = exc_i;
        n.tnew = (int'(tnew_i) - dec < 0) ? 0 : int'(tnew_i) - dec;
      end else begin
        n.ctrl = 0; n.a3 = 0; n.exc = 0; n.tnew = 0;
      end
    end
    return n;
  endfunction

  task automatic chk_model(input string tag, input st_t m, input logic v, input logic [31:0] pc,
                           input logic [7:0] ctrl, input logic [63:0] data, input logic [4:0] a3,
                           input logic [1:0] tn, input logic [4:0] exc, input logic bd, input logic fwd);
    chk({tag, "_valid"}, 64'(v), 64'(m.v));
    chk({tag, "_pc"}, 64'(pc), 64'(m.pc));
    chk({tag, "_ctrl"}, 64'(ctrl), 64'(m.ctrl));
    chk({tag, "_data"}, data, m.data);
    chk({tag, "_a3"}, 64'(a3), 64'(m.a3));
    chk({tag, "_tnew"}, 64'(tn), 64'(m.tnew));
    chk({tag, "_exc"}, 64'(exc), 64'(m.exc));
    chk({tag, "_bd"}, 64'(bd), 64'(m.bd));
    chk({tag, "_fwd"}, 64'(fwd), 64'(m.v && m.a3 != 0 && m.tnew == 0));
  endtask

  initial begin
    vecs[0]  = mk(0,1,1,1, 32'h3044, 8'hFF, 64'h1111_2222_3333_4444, 5'd7, 2'd3, 5'd5, 1,
                  0, 32'h3000, 8'h00, 64'h0, 5'd0, 2'd0, 5'd0, 0, 0, 2'd0, 0);
    vecs[1]  = mk(1,1,0,1, 32'h3010, 8'h5A, 64'h1234_5678_DEAD_BEEF, 5'd8, 2'd2, 5'd0, 0,
                  1, 32'h3010, 8'h5A, 64'h1234_5678_DEAD_BEEF, 5'd8, 2'd1, 5'd0, 0, 0, 2'd2, 0);
    vecs[2]  = mk(1,0,0,1, 32'h3FFC, 8'h01, 64'hAAAA_AAAA_5555_5555, 5'd3, 2'd0, 5'd1, 1,
                  1, 32'h3010, 8'h5A, 64'h1234_5678_DEAD_BEEF, 5'd8, 2'd1, 5'd0, 0, 0, 2'd2, 0);
    vecs[3]  = mk(1,0,0,0, 32'h3100, 8'h02, 64'h0, 5'd0, 2'd3, 5'd2, 0,
                  1, 32'h3010, 8'h5A, 64'h1234_5678_DEAD_BEEF, 5'd8, 2'd1, 5'd0, 0, 0, 2'd2, 0);
    vecs[4]  = mk(1,0,0,1, 32'h3200, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 2'd1, 5'd0, 1,
                  1, 32'h3010, 8'h5A, 64'h1234_5678_DEAD_BEEF, 5'd8, 2'd1, 5'd0, 0, 0, 2'd2, 0);
    vecs[5]  = mk(1,1,0,1, 32'h3014, 8'h33, 64'h0BAD_F00D_CAFE_0001, 5'd8, 2'd0, 5'd0, 0,
                  1, 32'h3014, 8'h33, 64'h0BAD_F00D_CAFE_0001, 5'd8, 2'd0, 5'd0, 0, 1, 2'd0, 1);
    vecs[6]  = mk(1,0,1,1, 32'h3024, 8'h11, 64'h9999_8888_7777_6666, 5'd3, 2'd2, 5'd2, 1,
                  0, 32'h3024, 8'h00, 64'h0, 5'd0, 2'd0, 5'd0, 1, 0, 2'd0, 0);
    vecs[7]  = mk(1,1,0,0, 32'h3028, 8'h77, 64'h0000_0001_0000_0002, 5'd9, 2'd2, 5'd4, 1,
                  0, 32'h3028, 8'h00, 64'h0000_0001_0000_0002, 5'd0, 2'd0, 5'd0, 1, 0, 2'd0, 0);
    vecs[8]  = mk(1,1,0,1, 32'h302C, 8'h01, 64'h0000_0003_0000_0004, 5'd0, 2'd0, 5'd0, 0,
                  1, 32'h302C, 8'h01, 64'h0000_0003_0000_0004, 5'd0, 2'd0, 5'd0, 0, 0, 2'd0, 0);
    vecs[9]  = mk(1,1,0,1, 32'h3030, 8'h80, 64'h5, 5'd31, 2'd3, 5'd12, 0,
                  1, 32'h3030, 8'h80, 64'h5, 5'd31, 2'd2, 5'd12, 0, 0, 2'd3, 0);
    vecs[10] = mk(1,1,0,1, 32'h3034, 8'h81, 64'h6, 5'd31, 2'd1, 5'd0, 1,
                  1, 32'h3034, 8'h81, 64'h6, 5'd31, 2'd0, 5'd0, 1, 1, 2'd1, 0);
    vecs[11] = mk(0,0,0,1, 32'h3038, 8'h82, 64'h7, 5'd2, 2'd3, 5'd3, 1,
                  0, 32'h3000, 8'h00, 64'h0, 5'd0, 2'd0, 5'd0, 0, 0, 2'd0, 0);

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst; en = vecs[i].en; flush = vecs[i].fl; valid_i = vecs[i].vi;
      pc_i = vecs[i].pc; ctrl_i = vecs[i].ctrl; data_i = vecs[i].data; a3_i = vecs[i].a3;
      tnew_i = vecs[i].tn; exc_i = vecs[i].exc; bd_i = vecs[i].bd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(d0_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_pc", i),    64'(d0_pc),    64'(vecs[i].epc));
      chk($sformatf("v%0d_ctrl", i),  64'(d0_ctrl),  64'(vecs[i].ectrl));
      chk($sformatf("v%0d_data", i),  d0_data,       vecs[i].edata);
      chk($sformatf("v%0d_a3", i),    64'(d0_a3),    64'(vecs[i].ea3));
      chk($sformatf("v%0d_tnew", i),  64'(d0_tnew),  64'(vecs[i].etn));
      chk($sformatf("v%0d_exc", i),   64'(d0_exc),   64'(vecs[i].eexc));
      chk($sformatf("v%0d_bd", i),    64'(d0_bd),    64'(vecs[i].ebd));
      chk($sformatf("v%0d_fwd", i),   64'(d0_fwd),   64'(vecs[i].efwd));
      chk($sformatf("v%0d_tnew_dec0", i), 64'(d1_tnew), 64'(vecs[i].etn1));
      chk($sformatf("v%0d_fwd_dec0", i),  64'(d1_fwd),  64'(vecs[i].efwd1));
    end

    // Flush with en high then a held bubble: PC/BD taken from flush edge, hold keeps them.
    reset = 1; en = 1; flush = 1; valid_i = 1; pc_i = 32'h3040; bd_i = 1; a3_i = 5'd4; tnew_i = 0;
    @(posedge clk); #1;
    chk("flush_en_valid", 64'(d0_valid), 64'd0);
    chk("flush_en_pc", 64'(d0_pc), 64'h3040);
    flush = 0; en = 0; pc_i = 32'h3050; bd_i = 0;
    @(posedge clk); #1;
    chk("bubble_hold_pc", 64'(d0_pc), 64'h3040);
    chk("bubble_hold_bd", 64'(d0_bd), 64'd1);

    m0 = '{1'b0, 32'h3040, 8'h0, 64'h0, 5'h0, 0, 5'h0, 1'b1};
    m1 = m0;
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 19) != 0);
      flush   = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      valid_i = ($urandom_range(0, 3) != 0);
      pc_i    = $urandom;
      ctrl_i  = 8'($urandom);
      data_i  = {$urandom, $urandom};
      a3_i    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      tnew_i  = 2'($urandom);
      exc_i   = 5'($urandom);
      bd_i    = 1'($urandom);
      m0 = model_next(m0, 1);
      m1 = model_next(m1, 0);
      @(posedge clk); #1;
      chk_model("r0", m0, d0_valid, d0_pc, d0_ctrl, d0_data, d0_a3, d0_tnew, d0_exc, d0_bd, d0_fwd);
      chk_model("r1", m1, d1_valid, d1_pc, d1_ctrl, d1_data, d1_a3, d1_tnew, d1_exc, d1_bd, d1_fwd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
